// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipe_stage slice.
package pipe_pkg;

    localparam int unsigned DATA_W = 32;
    localparam logic [DATA_W-1:0] NOP_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous active-high reset.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] MAX = '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage.sv
// Two-entry skid-buffered pipeline stage with stall/flush control and
// saturating stall/flush performance counters.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH = 32,
    parameter logic [WIDTH-1:0] NOP   = WIDTH'(NOP_DEFAULT),
    parameter int unsigned      CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    input  logic             stall,
    input  logic             flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             acc;
    logic             deq;

    // Handshake flags decode only the state register, keeping in_ready
    // free of any path from out_ready or stall.
    assign in_ready  = (state_q != SKID);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = out_valid ? main_q : NOP;

    assign acc = in_valid & in_ready;
    assign deq = out_valid & out_ready & ~stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= NOP;
            skid_q  <= NOP;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d = FULL;
                        main_d  = in_data;
                    end
                end
                FULL: begin
                    if (deq && acc) begin
                        main_d = in_data;
                    end else if (deq) begin
                        state_d = EMPTY;
                    end else if (acc) begin
                        state_d = SKID;
                        skid_d  = in_data;
                    end
                end
                SKID: begin
                    if (deq) begin
                        state_d = FULL;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_valid & ~deq),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stage.sv
// Self-checking bench for pipe_stage: directed vector table, saturation
// sequence and randomized traffic against a queue-based reference model.
module tb_pipe_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        stall;
    logic        flush;

    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [15:0] stall_cnt, flush_cnt;

    logic        in_ready4, out_valid4;
    logic [31:0] out_data4;
    logic [3:0]  stall_cnt4, flush_cnt4;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of held payloads (capacity 2) and counters.
    logic [31:0] mq[$];
    int m_sc, m_fc, m_sc4, m_fc4;

    pipe_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .stall     (stall),
        .flush     (flush),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    pipe_stage #(.CNT_W(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready4),
        .out_valid (out_valid4),
        .out_data  (out_data4),
        .out_ready (out_ready),
        .stall     (stall),
        .flush     (flush),
        .stall_cnt (stall_cnt4),
        .flush_cnt (flush_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        st;
        logic        fl;
        logic        ev;
        logic [31:0] ed;
        logic        er;
        int          esc;
        int          efc;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(logic r, logic iv, logic [31:0] d, logic ordy,
                                logic st, logic fl, logic ev, logic [31:0] ed,
                                logic er, int esc, int efc);
        vec_t v;
        v.r = r; v.iv = iv; v.d = d; v.ordy = ordy; v.st = st; v.fl = fl;
        v.ev = ev; v.ed = ed; v.er = er; v.esc = esc; v.efc = efc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int sat_inc(int v, int max);
        return (v < max) ? v + 1 : v;
    endfunction

    task automatic check_model();
        logic        ev;
        logic [31:0] ed;
        ev = (mq.size() > 0);
        ed = ev ? mq[0] : 32'h0;
        chk("m_out_valid", 32'(out_valid), 32'(ev));
        chk("m_out_data",  out_data, ed);
        chk("m_in_ready",  32'(in_ready), 32'(mq.size() < 2));
        chk("m_stall_cnt", 32'(stall_cnt), 32'(m_sc));
        chk("m_flush_cnt", 32'(flush_cnt), 32'(m_fc));
        chk("m4_stall_cnt", 32'(stall_cnt4), 32'(m_sc4));
        chk("m4_flush_cnt", 32'(flush_cnt4), 32'(m_fc4));
    endtask

    task automatic model_update();
        logic v, dq, ac;
        if (rst) begin
            mq.delete();
            m_sc = 0; m_fc = 0; m_sc4 = 0; m_fc4 = 0;
        end else begin
            v  = (mq.size() > 0);
            dq = v & out_ready & ~stall;
            ac = in_valid & (mq.size() < 2);
            if (v && !dq) begin
                m_sc  = sat_inc(m_sc, 65535);
                m_sc4 = sat_inc(m_sc4, 15);
            end
            if (flush) begin
                m_fc  = sat_inc(m_fc, 65535);
                m_fc4 = sat_inc(m_fc4, 15);
                mq.delete();
            end else begin
                if (dq) void'(mq.pop_front());
                if (ac) mq.push_back(in_data);
            end
        end
    endtask

    // One clock: drive inputs, check pre-edge outputs on the falling edge,
    // advance the model, then return just after the rising edge.
    task automatic cycle(input logic r, input logic iv, input logic [31:0] d,
                         input logic ordy, input logic st, input logic fl);
        rst = r; in_valid = iv; in_data = d; out_ready = ordy; stall = st; flush = fl;
        @(negedge clk);
        check_model();
        model_update();
        @(posedge clk);
        #1;
    endtask

    initial begin
        m_sc = 0; m_fc = 0; m_sc4 = 0; m_fc4 = 0;
        rst = 1'b1; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
        stall = 1'b0; flush = 1'b0;
        @(posedge clk);
        #1;

        //               r  iv d             ordy st fl  ev ed            er sc fc
        vecs[0]  = mk(1, 0, 32'h0,        0, 0, 0, 0, 32'h0,        1, 0, 0);
        vecs[1]  = mk(1, 0, 32'h0,        0, 0, 0, 0, 32'h0,        1, 0, 0);
        vecs[2]  = mk(0, 1, 32'h0F0AB220, 1, 0, 0, 1, 32'h0F0AB220, 1, 0, 0);
        vecs[3]  = mk(0, 1, 32'hA1A1A1A1, 1, 0, 0, 1, 32'hA1A1A1A1, 1, 0, 0);
        vecs[4]  = mk(0, 1, 32'hA2A2A2A2, 1, 0, 0, 1, 32'hA2A2A2A2, 1, 0, 0);
        vecs[5]  = mk(0, 1, 32'hA3A3A3A3, 1, 0, 0, 1, 32'hA3A3A3A3, 1, 0, 0);
        vecs[6]  = mk(0, 0, 32'h0,        1, 0, 0, 0, 32'h0,        1, 0, 0);
        vecs[7]  = mk(0, 1, 32'h0F0AB220, 1, 0, 0, 1, 32'h0F0AB220, 1, 0, 0);
        vecs[8]  = mk(0, 1, 32'h2F0F00FF, 1, 1, 0, 1, 32'h0F0AB220, 0, 1, 0);
        vecs[9]  = mk(0, 1, 32'hDEADBEEF, 1, 1, 0, 1, 32'h0F0AB220, 0, 2, 0);
        vecs[10] = mk(0, 0, 32'h0,        1, 0, 0, 1, 32'h2F0F00FF, 1, 2, 0);
        vecs[11] = mk(0, 0, 32'h0,        1, 0, 0, 0, 32'h0,        1, 2, 0);
        vecs[12] = mk(0, 1, 32'h11111111, 0, 0, 0, 1, 32'h11111111, 1, 2, 0);
        vecs[13] = mk(0, 1, 32'h22222222, 0, 0, 0, 1, 32'h11111111, 0, 3, 0);
        vecs[14] = mk(0, 1, 32'h33333333, 1, 0, 1, 0, 32'h0,        1, 3, 1);
        vecs[15] = mk(0, 0, 32'h0,        1, 0, 0, 0, 32'h0,        1, 3, 1);
        vecs[16] = mk(0, 1, 32'h44444444, 0, 0, 0, 1, 32'h44444444, 1, 3, 1);
        vecs[17] = mk(0, 1, 32'h55555555, 0, 0, 0, 1, 32'h44444444, 0, 4, 1);
        vecs[18] = mk(1, 1, 32'h66666666, 1, 1, 1, 0, 32'h0,        1, 0, 0);
        vecs[19] = mk(0, 0, 32'h0,        1, 0, 0, 0, 32'h0,        1, 0, 0);

        for (int i = 0; i < 20; i++) begin
            cycle(vecs[i].r, vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].st, vecs[i].fl);
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ev));
            chk($sformatf("v%0d_out_data", i),  out_data, vecs[i].ed);
            chk($sformatf("v%0d_in_ready", i),  32'(in_ready), 32'(vecs[i].er));
            chk($sformatf("v%0d_stall_cnt", i), 32'(stall_cnt), 32'(vecs[i].esc));
            chk($sformatf("v%0d_flush_cnt", i), 32'(flush_cnt), 32'(vecs[i].efc));
        end

        // Long stall with a held payload: 16-bit counter reaches 20, 4-bit saturates.
        cycle(0, 1, 32'h0F0AB220, 1, 0, 0);
        repeat (20) cycle(0, 0, 32'h0, 1, 1, 0);
        chk("sat_stall_cnt16", 32'(stall_cnt), 32'd20);
        chk("sat_stall_cnt4", 32'(stall_cnt4), 32'hF);
        chk("sat_out_data", out_data, 32'h0F0AB220);
        cycle(0, 0, 32'h0, 1, 0, 0);
        chk("sat_drained", 32'(out_valid), 32'd0);

        // Randomized traffic against the queue model.
        for (int n = 0; n < 600; n++) begin
            cycle(($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 2) != 0),
                  $urandom(),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 9) == 0));
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
        @(negedge clk);
        check_model();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
